// File: rtl/adc_stream_pkg.sv
// Shared types, header layout and helpers for the ADC frame-to-stream packer.
package adc_stream_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned SEQ_W         = 16;
    localparam int unsigned HDR_MAGIC_LSB = 24;
    localparam int unsigned HDR_COUNT_LSB = 16;
    localparam int unsigned HDR_SEQ_LSB   = 0;

    localparam logic [7:0] ADC_HDR_MAGIC = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } fsm_state_t;

    // Number of set bits in a channel mask (masks are at most 32 channels wide).
    function automatic logic [7:0] popcount32(input logic [31:0] mask);
        logic [7:0] cnt;
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + 8'(mask[i]);
        end
        return cnt;
    endfunction

    // Header word: magic, enabled-channel count, frame sequence number.
    function automatic logic [WORD_W-1:0] build_header(input logic [7:0]       count,
                                                       input logic [SEQ_W-1:0] seq);
        logic [WORD_W-1:0] w;
        w = '0;
        w[HDR_MAGIC_LSB +: 8]     = ADC_HDR_MAGIC;
        w[HDR_COUNT_LSB +: 8]     = count;
        w[HDR_SEQ_LSB   +: SEQ_W] = seq;
        return w;
    endfunction

endpackage

// File: rtl/adc_mask_next_idx.sv
// Priority search for the lowest enabled channel at or above / strictly above an index.
module adc_mask_next_idx
    import adc_stream_pkg::*;
#(
    parameter int unsigned N     = 9,
    parameter int unsigned IDX_W = 4
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] cur_idx,
    input  logic             inclusive,
    output logic             found_c,
    output logic [IDX_W-1:0] next_idx_c
);

    // Scan high to low so the lowest qualifying index is the one left standing.
    always_comb begin
        found_c    = 1'b0;
        next_idx_c = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (mask[i] && ((inclusive && (IDX_W'(i) >= cur_idx)) || (IDX_W'(i) > cur_idx))) begin
                found_c    = 1'b1;
                next_idx_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/adc_frame_stream_packer.sv
// Buffers captured ADC frames and streams header + enabled channel words to a FIFO.
module adc_frame_stream_packer
    import adc_stream_pkg::*;
#(
    parameter int unsigned WORDS_PER_FRAME = 9,
    parameter int unsigned HOLD_DEPTH      = 2,
    parameter int unsigned HEADER_EN       = 1,
    parameter int unsigned DROP_CNT_W      = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                frame_valid,
    input  logic [32*WORDS_PER_FRAME-1:0]       frame_words_packed,
    input  logic [WORDS_PER_FRAME-1:0]          ch_mask,
    output logic                                push_valid,
    output logic [31:0]                         push_data,
    input  logic                                push_ready,
    output logic [$clog2(HOLD_DEPTH+1)-1:0]     hold_level,
    output logic                                busy,
    output logic [15:0]                         frame_seq,
    output logic [DROP_CNT_W-1:0]               drop_count,
    input  logic                                drop_count_clear
);

    localparam int unsigned IDX_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam int unsigned PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(HOLD_DEPTH + 1);

    logic [WORD_W-1:0]          slot_word [HOLD_DEPTH][WORDS_PER_FRAME];
    logic [WORDS_PER_FRAME-1:0] slot_mask [HOLD_DEPTH];
    logic [SEQ_W-1:0]           slot_seq  [HOLD_DEPTH];

    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    fsm_state_t                 state;
    logic [IDX_W-1:0]           cur_idx;

    logic                       xfer_c;
    logic                       accept_c;
    logic                       drop_c;
    logic                       release_c;
    logic                       found_c;
    logic [IDX_W-1:0]           next_idx_c;
    logic [IDX_W-1:0]           search_from_c;
    logic                       search_incl_c;
    logic [WORDS_PER_FRAME-1:0] rd_mask_c;
    logic [LVL_W-1:0]           level_nxt_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(HOLD_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign xfer_c        = push_valid && push_ready;
    assign rd_mask_c     = slot_mask[rd_ptr];
    assign search_incl_c = (state != DATA);
    assign search_from_c = (state == DATA) ? cur_idx : '0;

    adc_mask_next_idx #(
        .N     (WORDS_PER_FRAME),
        .IDX_W (IDX_W)
    ) u_next_idx (
        .mask       (rd_mask_c),
        .cur_idx    (search_from_c),
        .inclusive  (search_incl_c),
        .found_c    (found_c),
        .next_idx_c (next_idx_c)
    );

    // Accept/drop decision against the registered level, slot release and next level.
    always_comb begin
        accept_c    = frame_valid && (hold_level < LVL_W'(HOLD_DEPTH));
        drop_c      = frame_valid && !(hold_level < LVL_W'(HOLD_DEPTH));
        release_c   = 1'b0;
        level_nxt_c = hold_level;
        case (state)
            IDLE:      release_c = (hold_level != '0) && (HEADER_EN == 0) && !found_c;
            HDR, DATA: release_c = xfer_c && !found_c;
            default:   release_c = 1'b0;
        endcase
        if (accept_c && !release_c) begin
            level_nxt_c = hold_level + LVL_W'(1);
        end else if (!accept_c && release_c) begin
            level_nxt_c = hold_level - LVL_W'(1);
        end
    end

    // Hold buffer storage; contents only matter once the slot is counted in hold_level.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            for (int i = 0; i < int'(WORDS_PER_FRAME); i++) begin
                slot_word[wr_ptr][i] <= frame_words_packed[WORD_W*i +: WORD_W];
            end
            slot_mask[wr_ptr] <= ch_mask;
            slot_seq[wr_ptr]  <= frame_seq;
        end
    end

    // Slot pointers, occupancy, sequence numbering and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            hold_level <= '0;
            busy       <= 1'b0;
            frame_seq  <= '0;
            drop_count <= '0;
        end else begin
            if (accept_c) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (release_c) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            hold_level <= level_nxt_c;
            // A slot stays counted until the FSM returns to IDLE, so occupancy alone covers busy.
            busy       <= (level_nxt_c != '0);
            if (frame_valid) begin
                frame_seq <= frame_seq + 16'(1);
            end
            if (drop_count_clear) begin
                drop_count <= drop_c ? DROP_CNT_W'(1) : '0;
            end else if (drop_c && !(&drop_count)) begin
                drop_count <= drop_count + DROP_CNT_W'(1);
            end
        end
    end

    // Stream FSM: header then enabled words of the oldest held frame, one per transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            push_valid <= 1'b0;
            push_data  <= '0;
            cur_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hold_level != '0) begin
                        if (HEADER_EN != 0) begin
                            push_data  <= build_header(popcount32(32'(rd_mask_c)), slot_seq[rd_ptr]);
                            push_valid <= 1'b1;
                            state      <= HDR;
                        end else if (found_c) begin
                            push_data  <= slot_word[rd_ptr][next_idx_c];
                            cur_idx    <= next_idx_c;
                            push_valid <= 1'b1;
                            state      <= DATA;
                        end
                    end
                end
                HDR, DATA: begin
                    if (xfer_c) begin
                        if (found_c) begin
                            push_data <= slot_word[rd_ptr][next_idx_c];
                            cur_idx   <= next_idx_c;
                            state     <= DATA;
                        end else begin
                            push_valid <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                    push_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_stream_packer.sv
// Bench for adc_frame_stream_packer: default instance plus a header-less, 2-bit drop counter instance.
module tb_adc_frame_stream_packer;

    localparam int unsigned WPF = 9;
    localparam int unsigned HD  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic             fv_a, pr_a, clr_a, pv_a, busy_a;
    logic [32*WPF-1:0] fw_a;
    logic [WPF-1:0]   m_a;
    logic [31:0]      pd_a;
    logic [1:0]       lvl_a;
    logic [15:0]      seq_a, dc_a;

    logic             fv_b, pr_b, clr_b, pv_b, busy_b;
    logic [32*WPF-1:0] fw_b;
    logic [WPF-1:0]   m_b;
    logic [31:0]      pd_b;
    logic [1:0]       lvl_b;
    logic [15:0]      seq_b;
    logic [1:0]       dc_b;

    adc_frame_stream_packer #(
        .WORDS_PER_FRAME (WPF), .HOLD_DEPTH (HD), .HEADER_EN (1), .DROP_CNT_W (16)
    ) dut_a (
        .clk (clk), .rst (rst), .frame_valid (fv_a), .frame_words_packed (fw_a),
        .ch_mask (m_a), .push_valid (pv_a), .push_data (pd_a), .push_ready (pr_a),
        .hold_level (lvl_a), .busy (busy_a), .frame_seq (seq_a), .drop_count (dc_a),
        .drop_count_clear (clr_a)
    );

    adc_frame_stream_packer #(
        .WORDS_PER_FRAME (WPF), .HOLD_DEPTH (HD), .HEADER_EN (0), .DROP_CNT_W (2)
    ) dut_b (
        .clk (clk), .rst (rst), .frame_valid (fv_b), .frame_words_packed (fw_b),
        .ch_mask (m_b), .push_valid (pv_b), .push_data (pd_b), .push_ready (pr_b),
        .hold_level (lvl_b), .busy (busy_b), .frame_seq (seq_b), .drop_count (dc_b),
        .drop_count_clear (clr_b)
    );

    int          checks = 0;
    int          passes = 0;
    logic [31:0] expq_a[$], expq_b[$], log_a[$], log_b[$];
    bit          lastq_a[$], lastq_b[$];
    int          pend_a = 0, pend_b = 0, mdrop_a = 0, mdrop_b = 0;
    logic [15:0] mseq_a = '0, mseq_b = '0;
    logic        pvp_a = 1'b0, prp_a = 1'b0, pvp_b = 1'b0, prp_b = 1'b0;
    logic [31:0] pdp_a = '0, pdp_b = '0;
    bit          armed = 1'b0;
    int          p0a, p0b;
    bit          dropa, dropb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [32*WPF-1:0] mk(input logic [31:0] base);
        logic [32*WPF-1:0] v;
        for (int i = 0; i < int'(WPF); i++) v[32*i +: 32] = base + 32'(i);
        return v;
    endfunction

    // Expected stream of one accepted frame: optional header, then enabled words in ascending order.
    task automatic model_frame(input bit is_b, input logic [32*WPF-1:0] fw,
                               input logic [WPF-1:0] mask, input logic [15:0] seq);
        int cnt;
        logic [31:0] w[$];
        cnt = 0;
        for (int i = 0; i < int'(WPF); i++) if (mask[i]) cnt++;
        if (!is_b) w.push_back({8'hA5, 8'(cnt), seq});
        for (int i = 0; i < int'(WPF); i++) if (mask[i]) w.push_back(fw[32*i +: 32]);
        for (int k = 0; k < w.size(); k++) begin
            if (is_b) begin expq_b.push_back(w[k]); lastq_b.push_back(k == w.size() - 1); end
            else      begin expq_a.push_back(w[k]); lastq_a.push_back(k == w.size() - 1); end
        end
        if (w.size() != 0) begin
            if (is_b) pend_b++;
            else      pend_a++;
        end
    endtask

    // Per-cycle comparison against the model, then model update from this cycle's inputs.
    always @(negedge clk) begin
        if (armed) begin
            p0a = pend_a;
            p0b = pend_b;
            if (pvp_a && !prp_a) begin
                chk("a_hold_valid", 32'(pv_a), 32'd1);
                chk("a_hold_data", pd_a, pdp_a);
            end
            if (pv_a) chk("a_valid_expected", 32'(expq_a.size() != 0), 32'd1);
            if (pv_a && pr_a && expq_a.size() != 0) begin
                chk("a_word", pd_a, expq_a.pop_front());
                if (lastq_a.pop_front()) pend_a--;
                log_a.push_back(pd_a);
            end
            chk("a_hold_level", 32'(lvl_a), 32'(p0a));
            chk("a_busy", 32'(busy_a), 32'(p0a != 0));
            chk("a_frame_seq", 32'(seq_a), 32'(mseq_a));
            chk("a_drop_count", 32'(dc_a), 32'(mdrop_a));

            if (pvp_b && !prp_b) begin
                chk("b_hold_valid", 32'(pv_b), 32'd1);
                chk("b_hold_data", pd_b, pdp_b);
            end
            if (pv_b) chk("b_valid_expected", 32'(expq_b.size() != 0), 32'd1);
            if (pv_b && pr_b && expq_b.size() != 0) begin
                chk("b_word", pd_b, expq_b.pop_front());
                if (lastq_b.pop_front()) pend_b--;
                log_b.push_back(pd_b);
            end
            chk("b_frame_seq", 32'(seq_b), 32'(mseq_b));
            chk("b_drop_count", 32'(dc_b), 32'(mdrop_b));

            pvp_a = pv_a; prp_a = pr_a; pdp_a = pd_a;
            pvp_b = pv_b; prp_b = pr_b; pdp_b = pd_b;

            if (rst) begin
                expq_a.delete(); lastq_a.delete(); expq_b.delete(); lastq_b.delete();
                pend_a = 0; pend_b = 0; mdrop_a = 0; mdrop_b = 0;
                mseq_a = '0; mseq_b = '0; pvp_a = 1'b0; pvp_b = 1'b0;
            end else begin
                dropa = fv_a && (p0a >= int'(HD));
                if (fv_a) begin
                    if (!dropa) model_frame(1'b0, fw_a, m_a, mseq_a);
                    mseq_a = mseq_a + 16'd1;
                end
                if (clr_a) mdrop_a = dropa ? 1 : 0;
                else if (dropa && mdrop_a < 65535) mdrop_a++;

                dropb = fv_b && (p0b >= int'(HD));
                if (fv_b) begin
                    if (!dropb) model_frame(1'b1, fw_b, m_b, mseq_b);
                    mseq_b = mseq_b + 16'd1;
                end
                if (clr_b) mdrop_b = dropb ? 1 : 0;
                else if (dropb && mdrop_b < 3) mdrop_b++;
            end
        end
    end

    task automatic send_a(input logic [31:0] base, input logic [WPF-1:0] mask);
        fw_a = mk(base); m_a = mask; fv_a = 1'b1;
        @(posedge clk); #1;
        fv_a = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] base, input logic [WPF-1:0] mask, input logic clr);
        fw_b = mk(base); m_b = mask; fv_b = 1'b1; clr_b = clr;
        @(posedge clk); #1;
        fv_b = 1'b0; clr_b = 1'b0;
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((expq_a.size() != 0 || expq_b.size() != 0 || pv_a || pv_b) && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        chk("drain_in_budget", 32'(c < budget), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d so far", passes, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        fv_a = 1'b0; fw_a = '0; m_a = '0; pr_a = 1'b1; clr_a = 1'b0;
        fv_b = 1'b0; fw_b = '0; m_b = '0; pr_b = 1'b1; clr_b = 1'b0;
        @(posedge clk); #1;
        armed = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_push_valid", 32'(pv_a), 32'd0);
        chk("rst_hold_level", 32'(lvl_a), 32'd0);
        chk("rst_frame_seq", 32'(seq_a), 32'd0);
        chk("rst_drop_count", 32'(dc_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);

        // Full mask, continuous ready: header then all nine words, first valid two cycles on.
        log_a.delete();
        send_a(32'h100, 9'h1FF);
        chk("lat_cycle1_valid", 32'(pv_a), 32'd0);
        @(posedge clk); #1;
        chk("lat_cycle2_valid", 32'(pv_a), 32'd1);
        chk("lat_cycle2_data", pd_a, 32'hA509_0000);
        drain(100);
        chk("full_count", 32'(log_a.size()), 32'd10);
        if (log_a.size() == 10) begin
            chk("full_w0", log_a[0], 32'hA509_0000);
            chk("full_w1", log_a[1], 32'h0000_0100);
            chk("full_w9", log_a[9], 32'h0000_0108);
        end

        // Sparse mask, then an all-masked frame that yields only its header.
        log_a.delete();
        send_a(32'h100, 9'b1_0000_0101);
        drain(100);
        send_a(32'h100, 9'h000);
        drain(100);
        chk("sparse_count", 32'(log_a.size()), 32'd5);
        if (log_a.size() == 5) begin
            chk("sparse_hdr", log_a[0], 32'hA503_0001);
            chk("sparse_w0", log_a[1], 32'h0000_0100);
            chk("sparse_w2", log_a[2], 32'h0000_0102);
            chk("sparse_w8", log_a[3], 32'h0000_0108);
            chk("zero_hdr", log_a[4], 32'hA500_0002);
        end

        // Random backpressure with periodic random frames; the model tracks drops and order.
        for (int c = 0; c < 200; c++) begin
            pr_a = 1'($urandom_range(0, 1));
            if ((c % 12) == 0 && c < 120) begin
                fw_a = mk(32'(c) << 12);
                m_a  = WPF'($urandom);
                fv_a = 1'b1;
            end else begin
                fv_a = 1'b0;
            end
            @(posedge clk); #1;
        end
        fv_a = 1'b0; pr_a = 1'b1;
        drain(300);

        // Fill the buffer while stalled, drop the third frame, then check sequence gaps.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        log_a.delete();
        pr_a = 1'b0;
        send_a(32'h300, 9'h001);
        send_a(32'h400, 9'h001);
        send_a(32'h500, 9'h001);
        chk("full_hold_level", 32'(lvl_a), 32'd2);
        chk("full_drop_count", 32'(dc_a), 32'd1);
        chk("full_frame_seq", 32'(seq_a), 32'd3);
        pr_a = 1'b1;
        drain(100);
        send_a(32'h600, 9'h001);
        drain(100);
        chk("gap_count", 32'(log_a.size()), 32'd6);
        if (log_a.size() == 6) begin
            chk("gap_hdr0", log_a[0], 32'hA501_0000);
            chk("gap_w0", log_a[1], 32'h0000_0300);
            chk("gap_hdr1", log_a[2], 32'hA501_0001);
            chk("gap_hdr3", log_a[4], 32'hA501_0003);
            chk("gap_w3", log_a[5], 32'h0000_0600);
        end

        // Reset while streaming data words with two frames held.
        pr_a = 1'b0;
        send_a(32'h700, 9'h1FF);
        send_a(32'h800, 9'h1FF);
        send_a(32'h900, 9'h1FF);
        pr_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pr_a = 1'b0;
        chk("mid_data_valid", 32'(pv_a), 32'd1);
        chk("mid_data_level", 32'(lvl_a), 32'd2);
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        chk("post_rst_valid", 32'(pv_a), 32'd0);
        chk("post_rst_level", 32'(lvl_a), 32'd0);
        chk("post_rst_seq", 32'(seq_a), 32'd0);
        chk("post_rst_drop", 32'(dc_a), 32'd0);
        pr_a = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Header-less instance: data-only frame, same two-cycle latency.
        log_b.delete();
        send_b(32'h200, 9'b0_0001_0010, 1'b0);
        chk("b_lat_cycle1_valid", 32'(pv_b), 32'd0);
        @(posedge clk); #1;
        chk("b_lat_cycle2_valid", 32'(pv_b), 32'd1);
        chk("b_lat_cycle2_data", pd_b, 32'h0000_0201);
        drain(100);
        chk("b_data_count", 32'(log_b.size()), 32'd2);
        if (log_b.size() == 2) chk("b_data_w4", log_b[1], 32'h0000_0204);

        // Header-less, all-masked frame: nothing emitted, slot released.
        send_b(32'h300, 9'h000, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("b_zero_level", 32'(lvl_b), 32'd0);
        chk("b_zero_busy", 32'(busy_b), 32'd0);
        chk("b_zero_no_words", 32'(log_b.size()), 32'd2);
        chk("b_zero_seq", 32'(seq_b), 32'd2);

        // 2-bit drop counter: five drops saturate at 3; clear with a drop gives 1; clear alone 0.
        pr_b = 1'b0;
        for (int k = 0; k < 7; k++) send_b(32'h500 + 32'(k) * 32'h10, 9'h001, 1'b0);
        chk("b_sat_drop", 32'(dc_b), 32'd3);
        chk("b_sat_level", 32'(lvl_b), 32'd2);
        send_b(32'h5F0, 9'h001, 1'b1);
        chk("b_clr_with_drop", 32'(dc_b), 32'd1);
        clr_b = 1'b1; @(posedge clk); #1; clr_b = 1'b0;
        chk("b_clr_alone", 32'(dc_b), 32'd0);
        pr_b = 1'b1;
        drain(100);
        chk("b_held_count", 32'(log_b.size()), 32'd4);
        if (log_b.size() == 4) begin
            chk("b_held_w0", log_b[2], 32'h0000_0500);
            chk("b_held_w1", log_b[3], 32'h0000_0510);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
